prio_intc: RTL and testbench

PRIO_INTC -- requirements
Module: prio_intc

---
 rtl/prio_intc_pkg.sv | 30 +++
 rtl/prio_intc_resolver.sv | 36 +++
 rtl/prio_intc.sv | 165 ++++++++++++++++
 tb/tb_prio_intc.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/prio_intc_pkg.sv
// Shared constants for the priority interrupt controller: FSM state encoding,
// register map, EOI command codes and the rotated-rank helper.
package prio_intc_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACK1 = 2'd1;
    localparam logic [1:0] ST_ACK2 = 2'd2;

    localparam logic [1:0] ADDR_CTRL = 2'd0;
    localparam logic [1:0] ADDR_IMR  = 2'd1;
    localparam logic [1:0] ADDR_CMD  = 2'd2;
    localparam logic [1:0] ADDR_BASE = 2'd3;

    localparam logic [2:0] CMD_NS_EOI = 3'b001;
    localparam logic [2:0] CMD_SP_EOI = 3'b011;

    localparam int CTRL_LTIM = 0;
    localparam int CTRL_AEOI = 1;
    localparam int CTRL_ROT  = 2;

    // Distance of id from the current highest-priority slot; smaller ranks higher.
    function automatic logic [4:0] prio_rank(input logic [3:0] id, input logic [3:0] ptr,
                                             input logic [4:0] n);
        logic [4:0] r;
        r = {1'b0, id} - {1'b0, ptr};
        if (id < ptr) r = r + n;
        return r;
    endfunction

endpackage

// File: rtl/prio_intc_resolver.sv
// Combinational rotated priority search: the first set request found walking
// upward (with wrap) from ptr wins.
module prio_intc_resolver
    import prio_intc_pkg::*;
#(
    parameter int NUM_IRQ = 8
) (
    input  logic [NUM_IRQ-1:0] req,
    input  logic [3:0]         ptr,
    output logic [3:0]         id,
    output logic               vld
);

    localparam logic [4:0] N5 = 5'(NUM_IRQ);

    logic [15:0] req16;
    logic [4:0]  idx;

    assign req16 = 16'(req);

    // Walk from lowest to highest priority so the last hit is the winner.
    always_comb begin
        id  = '0;
        vld = 1'b0;
        idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            idx = {1'b0, ptr} + 5'(i);
            if (idx >= N5) idx = idx - N5;
            if (req16[idx[3:0]]) begin
                vld = 1'b1;
                id  = idx[3:0];
            end
        end
    end

endmodule

// File: rtl/prio_intc.sv
// Fully nested priority interrupt controller with two-pulse INTA handshake.
// Define PRIO_INTC_ROTATE_EN to enable automatic priority rotation (CTRL.ROT).
module prio_intc
    import prio_intc_pkg::*;
#(
    parameter int NUM_IRQ = 8,
    parameter int VEC_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] ir,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [1:0]         addr,
    input  logic [15:0]        wdata,
    output logic [15:0]        rdata,
    input  logic               inta_n,
    output logic               int_o,
    output logic [VEC_W-1:0]   vec,
    output logic               vec_valid
);

    localparam logic [4:0] N5      = 5'(NUM_IRQ);
    localparam logic [3:0] SPUR_ID = 4'(NUM_IRQ - 1);

    logic [1:0]         state_q;
    logic [NUM_IRQ-1:0] irr_q, isr_q, ir_q;
    logic [15:0]        imr_q, base_q, rdata_q;
    logic [2:0]         ctrl_q;
    logic [3:0]         ptr_q, id_q;
    logic               spur_q, inta_q, vec_valid_q;
    logic [VEC_W-1:0]   vec_q;

    logic [NUM_IRQ-1:0] irr, elig, isr_n, irr_clr;
    logic [15:0]        isr16;
    logic [3:0]         w_id, s_id, eoi_id, ptr_n;
    logic [4:0]         eoi_inc;
    logic               w_vld, s_vld, int_raw, inta_edge, ack1, ack2;
    logic               eoi_ns, eoi_sp, sp_ok, eoi_hit;

    function automatic logic [NUM_IRQ-1:0] onehot(input logic [3:0] id);
        logic [15:0] t;
        t = 16'd1 << id;
        return t[NUM_IRQ-1:0];
    endfunction

    assign irr  = ctrl_q[CTRL_LTIM] ? ir : irr_q;
    assign elig = irr & ~imr_q[NUM_IRQ-1:0];

    prio_intc_resolver #(.NUM_IRQ(NUM_IRQ)) u_req_res (
        .req(elig), .ptr(ptr_q), .id(w_id), .vld(w_vld)
    );

    prio_intc_resolver #(.NUM_IRQ(NUM_IRQ)) u_isr_res (
        .req(isr_q), .ptr(ptr_q), .id(s_id), .vld(s_vld)
    );

    assign int_raw   = w_vld && (!s_vld || prio_rank(w_id, ptr_q, N5) < prio_rank(s_id, ptr_q, N5));
    assign inta_edge = !inta_n && inta_q;
    assign ack1      = (state_q == ST_IDLE) && inta_edge;
    assign ack2      = (state_q == ST_ACK1) && inta_edge;

    assign eoi_ns = wr_en && (addr == ADDR_CMD) && (wdata[15:13] == CMD_NS_EOI);
    assign eoi_sp = wr_en && (addr == ADDR_CMD) && (wdata[15:13] == CMD_SP_EOI);
    assign isr16  = 16'(isr_q);
    assign sp_ok  = ({1'b0, wdata[3:0]} < N5) && isr16[wdata[3:0]];

    // Acknowledge updates first, then any EOI command written in the same cycle.
    always_comb begin
        isr_n   = isr_q;
        irr_clr = '0;
        eoi_hit = 1'b0;
        eoi_id  = '0;
        if (ack1 && w_vld) begin
            isr_n   = isr_n | onehot(w_id);
            irr_clr = onehot(w_id);
        end
        if (ack2 && ctrl_q[CTRL_AEOI] && !spur_q) begin
            isr_n   = isr_n & ~onehot(id_q);
            eoi_hit = 1'b1;
            eoi_id  = id_q;
        end
        if (eoi_ns && s_vld) begin
            isr_n   = isr_n & ~onehot(s_id);
            eoi_hit = 1'b1;
            eoi_id  = s_id;
        end else if (eoi_sp && sp_ok) begin
            isr_n   = isr_n & ~onehot(wdata[3:0]);
            eoi_hit = 1'b1;
            eoi_id  = wdata[3:0];
        end
    end

    assign eoi_inc = {1'b0, eoi_id} + 5'd1;
    assign ptr_n   = (eoi_inc == N5) ? 4'd0 : eoi_inc[3:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            irr_q       <= '0;
            isr_q       <= '0;
            ir_q        <= '0;
            ctrl_q      <= '0;
            imr_q       <= '1;
            base_q      <= '0;
            ptr_q       <= '0;
            id_q        <= '0;
            spur_q      <= 1'b0;
            inta_q      <= 1'b1;
            vec_q       <= '0;
            vec_valid_q <= 1'b0;
            rdata_q     <= '0;
        end else begin
            ir_q        <= ir;
            inta_q      <= inta_n;
            // A new edge wins over an acknowledge clear of the same bit.
            irr_q       <= ctrl_q[CTRL_LTIM] ? '0 : ((irr_q & ~irr_clr) | (ir & ~ir_q));
            isr_q       <= isr_n;
            vec_valid_q <= 1'b0;
            if (eoi_hit && ctrl_q[CTRL_ROT]) ptr_q <= ptr_n;

            case (state_q)
                ST_IDLE: if (inta_edge) begin
                    state_q <= ST_ACK1;
                    id_q    <= w_vld ? w_id : SPUR_ID;
                    spur_q  <= !w_vld;
                end
                ST_ACK1: if (inta_edge) begin
                    state_q     <= ST_ACK2;
                    vec_q       <= VEC_W'(base_q + {12'd0, id_q});
                    vec_valid_q <= 1'b1;
                end
                default: state_q <= ST_IDLE;
            endcase

            if (wr_en) begin
                case (addr)
`ifdef PRIO_INTC_ROTATE_EN
                    ADDR_CTRL: ctrl_q <= wdata[2:0];
`else
                    ADDR_CTRL: ctrl_q <= {1'b0, wdata[1:0]};
`endif
                    ADDR_IMR:  imr_q  <= wdata;
                    ADDR_BASE: base_q <= wdata;
                    default: ;
                endcase
            end

            if (rd_en) begin
                case (addr)
                    ADDR_CTRL: rdata_q <= 16'(irr);
                    ADDR_IMR:  rdata_q <= imr_q;
                    ADDR_CMD:  rdata_q <= 16'(isr_q);
                    default:   rdata_q <= base_q;
                endcase
            end
        end
    end

    assign int_o     = int_raw && (state_q == ST_IDLE) && !reset;
    assign vec       = vec_q;
    assign vec_valid = vec_valid_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_prio_intc.sv
// Directed-vector bench for prio_intc (NUM_IRQ=8, VEC_W=8).
module tb_prio_intc;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  ir;
    logic        wr_en, rd_en;
    logic [1:0]  addr;
    logic [15:0] wdata, rdata;
    logic        inta_n, int_o, vec_valid;
    logic [7:0]  vec;
    logic [15:0] rv;

    int n_vec = 0;
    int n_bad = 0;

`ifdef PRIO_INTC_ROTATE_EN
    localparam logic [7:0] ROT_VEC = 8'h21;
`else
    localparam logic [7:0] ROT_VEC = 8'h20;
`endif

    always #5 clk = ~clk;

    prio_intc #(.NUM_IRQ(8), .VEC_W(8)) dut (
        .clk(clk), .reset(reset), .ir(ir), .wr_en(wr_en), .rd_en(rd_en),
        .addr(addr), .wdata(wdata), .rdata(rdata), .inta_n(inta_n),
        .int_o(int_o), .vec(vec), .vec_valid(vec_valid)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        wr_en = 1'b1; addr = a; wdata = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [15:0] d);
        rd_en = 1'b1; addr = a;
        tick();
        rd_en = 1'b0;
        d = rdata;
    endtask

    task automatic pulse_ir(input logic [7:0] m);
        ir = m;
        tick();
        ir = 8'h00;
    endtask

    task automatic ack(input string tag, input logic [7:0] ev);
        inta_n = 1'b0; tick();
        chk({tag, ".int_in_ack1"}, 32'(int_o), 32'd0);
        inta_n = 1'b1; tick();
        inta_n = 1'b0; tick();
        chk({tag, ".vv"}, 32'(vec_valid), 32'd1);
        chk({tag, ".vec"}, 32'(vec), 32'(ev));
        inta_n = 1'b1; tick();
        chk({tag, ".vv_drop"}, 32'(vec_valid), 32'd0);
    endtask

    initial begin
        reset = 1'b1; ir = '0; wr_en = 1'b0; rd_en = 1'b0; addr = '0; wdata = '0; inta_n = 1'b1;
        tick(); tick();
        chk("rst.int_o", 32'(int_o), 32'd0);
        chk("rst.vec", 32'(vec), 32'd0);
        chk("rst.vv", 32'(vec_valid), 32'd0);
        chk("rst.rdata", 32'(rdata), 32'd0);
        reset = 1'b0; tick();
        rd(2'd1, rv); chk("rst.imr", 32'(rv), 32'h0000_ffff);
        rd(2'd0, rv); chk("rst.irr", 32'(rv), 32'd0);

        // Basic edge-mode acknowledge of ir[3]
        wr(2'd0, 16'h0000); wr(2'd1, 16'h0000); wr(2'd3, 16'h0020);
        pulse_ir(8'h08);
        chk("t1.int_o", 32'(int_o), 32'd1);
        ack("t1", 8'h23);
        rd(2'd2, rv); chk("t1.isr", 32'(rv), 32'h0008);
        rd(2'd0, rv); chk("t1.irr_clr", 32'(rv), 32'd0);
        wr(2'd2, 16'h2000);
        rd(2'd2, rv); chk("t1.isr_eoi", 32'(rv), 32'd0);

        // Simultaneous ir[5] and ir[2]
        pulse_ir(8'h24);
        ack("t2a", 8'h22);
        chk("t2.nested_int", 32'(int_o), 32'd0);
        wr(2'd2, 16'h2000);
        chk("t2.int_after_eoi", 32'(int_o), 32'd1);
        ack("t2b", 8'h25);
        rd(2'd2, rv); chk("t2.isr", 32'(rv), 32'h0020);
        wr(2'd2, 16'h2000);

        // Lower request blocked by in-service ir[1]; out-of-range EOI ignored
        pulse_ir(8'h02);
        ack("t3a", 8'h21);
        pulse_ir(8'h10);
        chk("t3.blocked", 32'(int_o), 32'd0);
        wr(2'd2, 16'h6001);
        chk("t3.unblocked", 32'(int_o), 32'd1);
        ack("t3b", 8'h24);
        wr(2'd2, 16'h6009);
        rd(2'd2, rv); chk("t3.eoi_oor", 32'(rv), 32'h0010);
        wr(2'd2, 16'h6004);
        rd(2'd2, rv); chk("t3.eoi_sp", 32'(rv), 32'd0);
        wr(2'd2, 16'h2000);
        rd(2'd2, rv); chk("t3.eoi_empty", 32'(rv), 32'd0);

        // Level mode request withdrawn before acknowledge -> spurious
        wr(2'd0, 16'h0001);
        ir = 8'h40; tick();
        chk("t4.int_lvl", 32'(int_o), 32'd1);
        ir = 8'h00; tick();
        chk("t4.int_drop", 32'(int_o), 32'd0);
        ack("t4", 8'h27);
        rd(2'd2, rv); chk("t4.isr", 32'(rv), 32'd0);

        // Automatic EOI
        wr(2'd0, 16'h0002);
        pulse_ir(8'h01);
        ack("t5", 8'h20);
        rd(2'd2, rv); chk("t5.aeoi_isr", 32'(rv), 32'd0);

        // Rotation: after EOI of id 0, id 1 outranks id 0 only when enabled
        wr(2'd0, 16'h0004);
        pulse_ir(8'h01);
        ack("t6a", 8'h20);
        wr(2'd2, 16'h2000);
        pulse_ir(8'h03);
        chk("t6.int_o", 32'(int_o), 32'd1);
        ack("t6b", ROT_VEC);
        wr(2'd2, 16'h2000);
        wr(2'd0, 16'h0000);

        // Reset in ACK1 aborts the acknowledge
        pulse_ir(8'h08);
        inta_n = 1'b0; tick();
        inta_n = 1'b1;
        reset = 1'b1; tick();
        chk("t7.rst_vv", 32'(vec_valid), 32'd0);
        chk("t7.rst_int", 32'(int_o), 32'd0);
        reset = 1'b0;
        inta_n = 1'b0; tick();
        chk("t7.no_vv", 32'(vec_valid), 32'd0);
        inta_n = 1'b1; tick();
        chk("t7.int_o", 32'(int_o), 32'd0);
        rd(2'd1, rv); chk("t7.imr", 32'(rv), 32'h0000_ffff);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
